// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 32x64 register file: in-order buffering of
// write-back requests, one drain per cycle, and youngest-entry read forwarding.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_hold,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [ADDR_W-1:0]        ReadRegister1,
    output logic [ADDR_W-1:0]        ReadRegister2,
    input  logic [DATA_W-1:0]        ReadData1,
    input  logic [DATA_W-1:0]        ReadData2,
    output logic [DATA_W-1:0]        rd_data1,
    output logic [DATA_W-1:0]        rd_data2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0]  entry_valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  slot;

    logic push_fire;
    logic enq;
    logic pop;

    // Full and empty come from count; head == tail is ambiguous on its own.
    assign wb_ready  = (count != CNT_W'(DEPTH));
    assign push_fire = wb_valid & wb_ready;
    assign enq       = push_fire & (wb_addr != ZERO_REG);
    assign pop       = (count != '0) & ~wb_hold;

    assign RegWrite      = pop;
    assign WriteRegister = entry_addr[head];
    assign WriteData     = entry_data[head];
    assign ReadRegister1 = rd_addr1;
    assign ReadRegister2 = rd_addr2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                head              <= head + PTR_W'(1);
                entry_valid[head] <= 1'b0;
            end
            if (enq) begin
                tail              <= tail + PTR_W'(1);
                entry_valid[tail] <= 1'b1;
            end
            count <= count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    // NOTE: payload storage is deliberately left out of reset; the valid bits
    // alone decide whether an entry is live, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_addr[tail] <= wb_addr;
            entry_data[tail] <= wb_data;
        end
    end

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;
        rd_data1 = ReadData1;
        rd_data2 = ReadData2;
        slot     = head;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if (entry_valid[slot] && entry_addr[slot] == rd_addr1 && rd_addr1 != ZERO_REG) begin
                fwd_hit1 = 1'b1;
                rd_data1 = entry_data[slot];
            end
            if (entry_valid[slot] && entry_addr[slot] == rd_addr2 && rd_addr2 != ZERO_REG) begin
                fwd_hit2 = 1'b1;
                rd_data2 = entry_data[slot];
            end
        end
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back buffer and read-forwarding front end that drives the 32x64 register file's single write port and two read ports.
- Accepts write-back requests from the datapath through a valid/ready handshake and holds them in a small in-order FIFO.
- Drains at most one entry per cycle into the register file.
- Merges still-pending queue data into read results, so readers always see the youngest committed value.
- Register 31 is the hard-wired zero register.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
ADDR_W, 5, register index width
DATA_W, 64, register data width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
wb_valid  input  1  write-back request present
wb_ready  output  1  queue can accept the request this cycle
wb_addr  input  ADDR_W  destination register of the request
wb_data  input  DATA_W  data of the request
wb_hold  input  1  when 1, suppress draining this cycle
RegWrite  output  1  register file write enable
WriteRegister  output  ADDR_W  register file write index
WriteData  output  DATA_W  register file write data
rd_addr1  input  ADDR_W  read index, port 1
rd_addr2  input  ADDR_W  read index, port 2
ReadRegister1  output  ADDR_W  to register file; equals rd_addr1
ReadRegister2  output  ADDR_W  to register file; equals rd_addr2
ReadData1  input  DATA_W  register file read data, port 1
ReadData2  input  DATA_W  register file read data, port 2
rd_data1  output  DATA_W  forwarded-or-file data, port 1
rd_data2  output  DATA_W  forwarded-or-file data, port 2
fwd_hit1  output  1  rd_data1 sourced from queue
fwd_hit2  output  1  rd_data2 sourced from queue
count  output  clog2(DEPTH)+1  current number of queued entries

Behaviour:
- Reset (async, immediate):
  - count=0; head and tail pointers=0; all entry valid bits=0.
  - Outputs: RegWrite=0, wb_ready=1, fwd_hit1/2=0.
  - Entry data/addr need not be cleared.
  - Reset mid-operation discards all pending writes; none reach the register file.
- wb_ready = (count != DEPTH). A push whose handshake completes while full is impossible.
  - No same-cycle push-on-pop credit when full.
- Push: wb_valid & wb_ready at a rising edge.
  - If wb_addr != 31, entry {wb_addr, wb_data} is written at tail; tail advances mod DEPTH.
  - If wb_addr == 31, the handshake completes but nothing is enqueued (silently dropped).
- Drain (combinational from head):
  - RegWrite = (count != 0) & ~wb_hold.
  - WriteRegister/WriteData = head entry. When count == 0 they hold the last head contents (don't-care).
  - On a rising edge with RegWrite=1, head advances; the register file captures the same edge.
- Simultaneous push and pop: count unchanged.
  - Ordering is strictly FIFO: entries drain in acceptance order, including repeated writes to the same register.
- Latency:
  - Accepted request in an empty queue with wb_hold=0: RegWrite=1 the cycle after acceptance.
  - Data is visible from the register file two edges after acceptance.
  - It is forwarded from the cycle after acceptance.
- Forwarding, combinational, per port n:
  - Search all valid entries (head through tail-1) for addr == rd_addrn.
  - The youngest matching entry wins: fwd_hitn=1, rd_datan = that entry's data.
  - Otherwise fwd_hitn=0, rd_datan = ReadDatan.
  - The head entry being written this cycle is still forwarded, because the file updates only at the edge.
  - The incoming, not-yet-accepted wb request is never forwarded.
  - rd_addrn == 31: fwd_hitn=0 and rd_datan = ReadDatan (zero).
- Pointer wrap: both pointers wrap mod DEPTH.
  - Full/empty are distinguished by count, not by pointer equality.
- wb_hold held high: queue fills to DEPTH, wb_ready drops, forwarding continues over all DEPTH entries.

Test Plan:
- Reset mid-stream:
  - Stimulus: push 3 entries with wb_hold=1, then assert reset between edges.
  - Required response: count=0, wb_ready=1, RegWrite=0 immediately.
  - After reset release and 5 idle cycles, no RegWrite pulses occur.
- Basic write and forward:
  - Stimulus: push {addr=5, data=0xAAAA} into an empty queue; rd_addr1=5.
  - Next cycle: fwd_hit1=1, rd_data1=0xAAAA, RegWrite=1, WriteRegister=5.
  - Following cycle: fwd_hit1=0, rd_data1=0xAAAA from the file.
- Youngest-wins forwarding:
  - Stimulus: with wb_hold=1, push {3,0x11}, {3,0x22}, {7,0x33}; rd_addr1=3, rd_addr2=7.
  - Required response: rd_data1=0x22, rd_data2=0x33.
  - Release hold: WriteRegister sequence is 3,3,7 with data 0x11,0x22,0x33.
- Full and wrap:
  - Stimulus: with wb_hold=1, push 4 entries; then drive wb_valid=1.
  - Required response: count=4, wb_ready=0, and the fifth request is not accepted.
  - Release hold: one entry drains per cycle; push 6 more entries interleaved.
  - Required response: all 10 writes reach the file in order across pointer wrap.
- Zero register:
  - Stimulus: push {31,0xFFFF}.
  - Required response: handshake completes, count stays 0, no RegWrite.
  - Stimulus: rd_addr1=31. Required response: fwd_hit1=0, rd_data1=0.
- Simultaneous push/pop:
  - Stimulus: count=2, wb_hold=0, push each cycle for 8 cycles.
  - Required response: count stays 2 and RegWrite=1 on every cycle.
